// File: rtl/interpolation_ram_pkg.sv
// Shared sizing for the interpolation sample RAM.
// Both ports use the same address and data widths.
`timescale 1ns/1ps
package interpolation_ram_pkg;

  localparam int RAM_ADDR_WIDTH = 11;
  localparam int RAM_DATA_WIDTH = 32;
  localparam int RAM_DEPTH      = 1 << RAM_ADDR_WIDTH;

endpackage

// File: rtl/interpolation_ram_sdp_ram_core.sv
// Simple dual-port RAM core: one write port, one registered read port.
// Read-first on same-address collisions across coincident edges.
`timescale 1ns/1ps
module sdp_ram_core
  import interpolation_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register carries the reset; the array itself never resets.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/interpolation_ram.sv
// Interpolation sample RAM: wraps the dual-port core and
// applies the write-domain reset as a write blocker.
`timescale 1ns/1ps
module interpolation_ram
  import interpolation_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic wr_en_q;

  // Gate combinationally so a write is blocked as soon as reset rises.
  assign wr_en_q = wr_en & ~tb_wr_rst;

  sdp_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .wr_clk  (wr_clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_interpolation_ram.sv
// Self-checking bench for interpolation_ram against an array model.
// Covers reset, fill/readback, gating, collision, resets, async clocks.
`timescale 1ns/1ps
module tb_interpolation_ram;

  logic        wr_clk = 1'b0;
  logic        rd_clk = 1'b0;
  logic        tb_wr_rst = 1'b1;
  logic        rd_rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [10:0] rd_addr = '0;
  logic [31:0] rd_data;

  int wr_half = 5;
  int rd_half = 5;

  int total = 0;
  int bad = 0;

  logic [31:0] model [2048];
  bit          valid [2048];

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  interpolation_ram dut (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge wr_clk);
    wr_en = 1'b1;
    wr_addr = a[10:0];
    wr_data = d;
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0;
    if (!tb_wr_rst) begin
      model[a] = d;
      valid[a] = 1'b1;
    end
  endtask

  task automatic rd(input int a, output logic [31:0] q);
    @(negedge rd_clk);
    rd_addr = a[10:0];
    @(posedge rd_clk);
    #1;
    q = rd_data;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge rd_clk);
      #1;
      total++;
      if (rd_data !== 32'h0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%h exp=00000000", i, rd_data);
      end
    end
    @(negedge wr_clk);
    tb_wr_rst = 1'b0;
    rd_rst = 1'b0;
  endtask

  task automatic test_fill_readback();
    logic [31:0] q;
    logic [31:0] exp;
    int a;
    int errs;
    for (int k = 1; k < 2048; k++) begin
      wr(k, 32'hFFFFFFFF - 32'(k - 1));
    end
    wr(0, 32'hFFFFF800);
    errs = 0;
    for (int i = 0; i < 2048; i++) begin
      a = (i == 2047) ? 0 : i + 1;
      exp = (a == 0) ? 32'hFFFFF800 : 32'hFFFFFFFF - 32'(a - 1);
      rd(a, q);
      total++;
      if (q !== exp) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL fill_readback addr=%0d got=%h exp=%h", a, q, exp);
      end
    end
  endtask

  task automatic test_wr_en_gating();
    logic [31:0] q;
    wr(5, 32'h12345678);
    @(negedge wr_clk);
    wr_en = 1'b0;
    wr_addr = 11'd5;
    wr_data = 32'hDEADBEEF;
    @(posedge wr_clk);
    #1;
    rd(5, q);
    total++;
    if (q !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_en_gating got=%h exp=12345678", q);
    end
  endtask

  task automatic test_collision();
    logic [31:0] q;
    wr(10, 32'h55555555);
    @(negedge wr_clk);
    wr_en = 1'b1;
    wr_addr = 11'd10;
    wr_data = 32'hAAAAAAAA;
    rd_addr = 11'd10;
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0;
    model[10] = 32'hAAAAAAAA;
    total++;
    if (rd_data !== 32'h55555555) begin
      bad++;
      $display("FAIL collision_old got=%h exp=55555555", rd_data);
    end
    rd(10, q);
    total++;
    if (q !== 32'hAAAAAAAA) begin
      bad++;
      $display("FAIL collision_new got=%h exp=aaaaaaaa", q);
    end
  endtask

  task automatic test_wr_rst_block();
    logic [31:0] q;
    wr(20, 32'h0BADF00D);
    wr(21, 32'h600DCAFE);
    #3;
    tb_wr_rst = 1'b1;
    wr(20, 32'h11111111);
    wr(21, 32'h22222222);
    wr(22, 32'h33333333);
    @(negedge wr_clk);
    tb_wr_rst = 1'b0;
    for (int a = 19; a <= 21; a++) begin
      rd(a, q);
      total++;
      if (q !== model[a]) begin
        bad++;
        $display("FAIL wr_rst_block addr=%0d got=%h exp=%h", a, q, model[a]);
      end
    end
  endtask

  task automatic test_rd_rst_mid();
    logic [31:0] q;
    for (int a = 100; a < 140; a++) begin
      rd(a, q);
      total++;
      if (q !== model[a]) begin
        bad++;
        $display("FAIL rd_rst_mid addr=%0d got=%h exp=%h", a, q, model[a]);
      end
      if (a == 120) begin
        #1;
        rd_rst = 1'b1;
        #1;
        total++;
        if (rd_data !== 32'h0) begin
          bad++;
          $display("FAIL rd_rst_immediate got=%h exp=00000000", rd_data);
        end
        for (int j = 0; j < 3; j++) begin
          @(posedge rd_clk);
          #1;
          total++;
          if (rd_data !== 32'h0) begin
            bad++;
            $display("FAIL rd_rst_hold[%0d] got=%h exp=00000000", j, rd_data);
          end
        end
        @(negedge rd_clk);
        rd_rst = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] q;
    logic [31:0] d;
    int a;
    int b;
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 2047));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge wr_clk);
        wr_en = 1'b0;
        wr_addr = a[10:0];
        wr_data = d;
        @(posedge wr_clk);
        #1;
      end else begin
        wr(a, d);
      end
      b = ($urandom_range(0, 1) == 1) ? a : int'($urandom_range(0, 2047));
      if (!valid[b]) b = a;
      if (valid[b]) begin
        rd(b, q);
        total++;
        if (q !== model[b]) begin
          bad++;
          $display("FAIL random[%0d] addr=%0d got=%h exp=%h", i, b, q, model[b]);
        end
      end
    end
  endtask

  task automatic test_async_clocks();
    logic [31:0] q;
    int errs;
    rd_half = 7;
    for (int a = 0; a < 2048; a++) begin
      wr(a, $urandom);
    end
    errs = 0;
    for (int a = 0; a < 2048; a++) begin
      rd(a, q);
      total++;
      if (q !== model[a]) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL async_read addr=%0d got=%h exp=%h", a, q, model[a]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      valid[i] = 1'b0;
      model[i] = '0;
    end
    test_reset();
    test_fill_readback();
    test_wr_en_gating();
    test_collision();
    test_wr_rst_block();
    test_rd_rst_mid();
    test_random();
    test_async_clocks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interpolation_ram.md
INTERPOLATION_RAM -- requirements
Module: interpolation_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, address width of both ports; depth is 2**ADDR_WIDTH = 2048 words.
REQ-002 Parameter DATA_WIDTH, default 32, word width of both ports; the two ports have the same width.
REQ-003 wr_clk  input  1  write-port clock; the write reset is tb_wr_rst, asynchronous, active-high; the write clock is wr_clk.
REQ-004 tb_wr_rst  input  1  write-domain reset, asynchronous, active-high.
REQ-005 rd_clk  input  1  read-port clock, independent of wr_clk; no phase or frequency relation is required.
REQ-006 rd_rst  input  1  read-domain reset, asynchronous, active-high.
REQ-007 wr_en  input  1  write enable, sampled on the wr_clk rising edge.
REQ-008 wr_addr  input  ADDR_WIDTH  write address.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 rd_addr  input  ADDR_WIDTH  read address, sampled every rd_clk rising edge; there is no read enable.
REQ-011 rd_data  output  DATA_WIDTH  registered read data.

Function
REQ-012 The block SHALL be a simple dual-port RAM: one write port and one read port, 2048 x 32 bits.
REQ-013 Write: on a wr_clk rising edge with wr_en=1, mem[wr_addr] takes wr_data; with wr_en=0 the memory is unchanged.
REQ-014 Read: on every rd_clk rising edge, rd_data takes mem[rd_addr].
REQ-015 Read latency SHALL be exactly 1 rd_clk cycle: there is no output register stage, no output clock-enable and no clock inversion.
REQ-016 Addresses SHALL cover the full range 0..2047 with no aliasing; address 2047 is legal and distinct from address 0.
REQ-017 Same-address collision: if a write and a read hit the same address on coincident edges, rd_data SHALL return the old contents (read-first); the new data is visible on the next read.
REQ-018 Memory contents SHALL be uninitialised (no init file); only written locations are defined.
REQ-019 There SHALL be no byte enables and no address-strobe or clock-enable inputs.

Reset
REQ-020 rd_rst=1 SHALL clear rd_data to 0 asynchronously and hold it at 0 while asserted.
REQ-021 tb_wr_rst=1 SHALL block writes while asserted.
REQ-022 Neither reset SHALL alter memory contents.
REQ-023 A reset asserted mid-operation SHALL corrupt no location other than one whose write edge coincides with the reset assertion.
REQ-024 After rd_rst is released, the first rd_clk edge SHALL deliver valid data.
REQ-025 The block SHALL operate correctly with a global-reset primitive GTP_GRS instantiated at top level with GRS_N=1; GRS SHALL have no functional effect when inactive.

Structure
REQ-026 A shared package SHALL hold ADDR_WIDTH=11, DATA_WIDTH=32 and DEPTH=2048.
REQ-027 One natural sub-module SHALL be sdp_ram_core, containing the memory array, the write logic and the read register.
REQ-028 interpolation_ram SHALL wrap sdp_ram_core and add the reset handling.
REQ-029 The design SHALL be inferable to block RAM.

Verification
REQ-030 Reset check: hold both resets for 200 ns -> rd_data = 0x00000000 throughout.
REQ-031 Fill and readback:
- write addr k (k = 1..2047) with data 0xFFFFFFFF-(k-1), then addr 0 with 0xFFFFF800;
- sweep rd_addr 1..2047, then 0, at 10 ns clocks;
- rd_data SHALL equal the written value exactly one rd_clk later, e.g. addr 1 -> 0xFFFFFFFF, addr 2047 -> 0xFFFFF801, addr 0 -> 0xFFFFF800;
- zero mismatches.
REQ-032 Write-enable gating: write 0x12345678 to addr 5, then present 0xDEADBEEF at addr 5 with wr_en=0 -> reading addr 5 returns 0x12345678.
REQ-033 Collision: write 0xAAAAAAAA to addr 10 on the same edge that addr 10 is read while holding 0x55555555 -> rd_data = 0x55555555, next read = 0xAAAAAAAA.
REQ-034 Reset mid-operation: assert rd_rst while reading a filled RAM -> rd_data goes to 0 immediately; after release, reads resume with the correct data, memory intact.
REQ-035 Asynchronous clocks: wr_clk at 10 ns and rd_clk at 14 ns, fill then read all addresses -> all data correct.
